// File: rtl/pixel_readout_capture.sv
// rtl/pixel_readout_capture.sv - samples the shared pixel bus once per row read strobe into a show-ahead FIFO
// Each settled strobe yields one {row, pixel} entry, which is presented on a valid/ready stream.
module pixel_readout_capture #(
  parameter int SETTLE = 2,
  parameter int DEPTH  = 8,
  parameter int DW     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1,
  localparam int SW    = $clog2(SETTLE + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          read0_i,
  input  logic          read1_i,
  input  logic          read2_i,
  input  logic          read3_i,
  input  logic [DW-1:0] pix_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    out_row_o,
  output logic          out_last_o,
  output logic          frame_done_o,
  output logic [CW-1:0] fifo_count_o,
  output logic          overflow_o,
  output logic          multi_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT_LOW} state_t;

  localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  state_t           state_q;
  logic [SW-1:0]    cnt_q;
  logic [1:0]       idx_q;
  logic             overflow_q, multi_err_q, frame_done_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [DW+1:0]    mem_q [DEPTH];

  logic [3:0]       rd_w;
  logic             any_w, one_w, multi_w, same_w;
  logic [1:0]       idx_w;
  logic             push_w, full_w, pop_w, wr_en_w;

  always_comb begin
    rd_w    = {read3_i, read2_i, read1_i, read0_i};
    any_w   = |rd_w;
    one_w   = $onehot(rd_w);
    multi_w = any_w && !one_w;
    idx_w   = 2'd0;
    case (rd_w)
      4'b0010: idx_w = 2'd1;
      4'b0100: idx_w = 2'd2;
      4'b1000: idx_w = 2'd3;
      default: idx_w = 2'd0;
    endcase
    same_w  = one_w && (idx_w == idx_q);
    push_w  = (state_q == S_SETTLE) && same_w && (cnt_q == SETTLE_C);
    full_w  = (count_q == DEPTH_C);
    pop_w   = out_valid_o && out_ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    wr_en_w = push_w && (!full_w || pop_w);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      overflow_q   <= 1'b0;
      multi_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (one_w) begin
            state_q <= S_SETTLE;
            idx_q   <= idx_w;
            cnt_q   <= SW'(1);
          end else if (multi_w) begin
            state_q <= S_WAIT_LOW;
          end
        end
        S_SETTLE: begin
          if (same_w) begin
            if (cnt_q == SETTLE_C) state_q <= S_WAIT_LOW;
            else                   cnt_q   <= cnt_q + 1'b1;
          end else if (!any_w) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!any_w) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (multi_w)             multi_err_q <= 1'b1;
      if (push_w && !wr_en_w)  overflow_q  <= 1'b1;
      frame_done_q <= wr_en_w && (idx_q == 2'd3);

      if (wr_en_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en_w, pop_w})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_w) mem_q[wr_ptr_q] <= {idx_q, pix_data_i};
  end

  // Head fields are masked while empty so stale storage never shows after reset.
  always_comb begin
    out_valid_o  = (count_q != '0);
    out_data_o   = out_valid_o ? mem_q[rd_ptr_q][DW-1:0] : '0;
    out_row_o    = out_valid_o ? mem_q[rd_ptr_q][DW+1:DW] : 2'd0;
    out_last_o   = out_valid_o && (out_row_o == 2'd3);
    frame_done_o = frame_done_q;
    fifo_count_o = count_q;
    overflow_o   = overflow_q;
    multi_err_o  = multi_err_q;
  end

endmodule

// File: tb/tb_pixel_readout_capture.sv
// tb/tb_pixel_readout_capture.sv - scoreboard bench for pixel_readout_capture
module tb_pixel_readout_capture;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       read0 = 1'b0, read1 = 1'b0, read2 = 1'b0, read3 = 1'b0;
  logic [7:0] pix = 8'h00;
  logic       out_valid, out_ready = 1'b0, out_last, frame_done, overflow, multi_err;
  logic [7:0] out_data;
  logic [1:0] out_row;
  logic [3:0] fifo_count;

  int total = 0;
  int bad = 0;
  int frame_cnt = 0;
  int fd_start;
  logic [9:0] exp_q[$];

  pixel_readout_capture #(.SETTLE(2), .DEPTH(8), .DW(8)) dut (
    .clk_i(clk), .reset_i(reset),
    .read0_i(read0), .read1_i(read1), .read2_i(read2), .read3_i(read3),
    .pix_data_i(pix),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_row_o(out_row), .out_last_o(out_last),
    .frame_done_o(frame_done), .fifo_count_o(fifo_count),
    .overflow_o(overflow), .multi_err_o(multi_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (frame_done) frame_cnt++;
      if (out_valid && out_ready) begin
        logic [9:0] e;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e[7:0]);
          check("beat_row", out_row, e[9:8]);
          check("beat_last", out_last, (e[9:8] == 2'd3));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_strobes(input logic [3:0] s);
    {read3, read2, read1, read0} = s;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    set_strobes(4'b0000);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One strobe held 3 cycles, then a low cycle.
  task automatic do_read(input int row, input logic [7:0] d, input bit expect_push);
    logic [1:0] r;
    r = row[1:0];
    if (expect_push) exp_q.push_back({r, d});
    for (int k = 0; k < 3; k++) begin
      tick();
      set_strobes(4'b0001 << row);
      pix = d;
    end
    tick();
    set_strobes(4'b0000);
    pix = 8'hEE;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_multi", multi_err, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_data", out_data, 0);

    // 1: held strobe, changing bus -> single sample of the value at t+2, visible at t+3
    out_ready = 1'b1;
    exp_q.push_back({2'd0, 8'h12});
    for (int k = 0; k < 5; k++) begin
      tick();
      read0 = 1'b1;
      pix = 8'h10 + 8'(k);
      @(negedge clk);
      if (k == 2) check("t1_valid_t2", out_valid, 0);
      if (k == 3) check("t1_valid_t3", out_valid, 1);
    end
    tick();
    read0 = 1'b0;
    idle(4);
    @(negedge clk);
    check("t1_count", fifo_count, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: one frame across rows 0..3
    fd_start = frame_cnt;
    do_read(0, 8'hA0, 1);
    do_read(1, 8'hB1, 1);
    do_read(2, 8'hC2, 1);
    do_read(3, 8'hD3, 1);
    idle(4);
    @(negedge clk);
    check("t2_frame_pulses", frame_cnt - fd_start, 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: fill with no consumer, ninth sample dropped, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) do_read(i % 4, 8'h30 + 8'(i), i < 8);
    idle(2);
    @(negedge clk);
    check("t3_count_full", fifo_count, 8);
    check("t3_overflow", overflow, 1);
    check("t3_head_held", out_data, 8'h30);
    tick();
    out_ready = 1'b1;
    begin
      int budget = 50;
      while (fifo_count != 0 && budget > 0) begin
        tick();
        budget--;
      end
      check("t3_drain_timeout", (budget > 0), 1);
    end
    idle(2);
    @(negedge clk);
    check("t3_queue_empty", exp_q.size(), 0);
    check("t3_overflow_sticky", overflow, 1);

    // 4: two strobes together -> error, nothing until all low, then normal capture
    do_reset();
    tick(); set_strobes(4'b0110);
    idle(3);
    set_strobes(4'b0100);
    idle(4);
    set_strobes(4'b0000);
    idle(2);
    @(negedge clk);
    check("t4_multi_err", multi_err, 1);
    check("t4_count", fifo_count, 0);
    check("t4_overflow", overflow, 0);
    do_read(1, 8'h55, 1);
    idle(3);
    @(negedge clk);
    check("t4_after_queue_empty", exp_q.size(), 0);

    // 5: strobe shorter than the settle time
    do_reset();
    tick(); set_strobes(4'b0100); pix = 8'h77;
    tick(); set_strobes(4'b0000);
    idle(4);
    @(negedge clk);
    check("t5_count", fifo_count, 0);
    check("t5_multi", multi_err, 0);
    check("t5_overflow", overflow, 0);
    check("t5_frame_pulse_none", frame_done, 0);

    // 6: reset with stored entries and a capture in progress
    out_ready = 1'b0;
    do_read(0, 8'h61, 1);
    do_read(1, 8'h62, 1);
    do_read(2, 8'h63, 1);
    @(negedge clk);
    check("t6_count_before", fifo_count, 3);
    tick(); set_strobes(4'b1000); pix = 8'h99;
    tick(); set_strobes(4'b0000); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("t6_valid", out_valid, 0);
    check("t6_count", fifo_count, 0);
    check("t6_flags", {overflow, multi_err, frame_done}, 0);
    idle(4);
    @(negedge clk);
    check("t6_no_late_push", fifo_count, 0);
    check("t6_no_frame_done", frame_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
